// File: rtl/config_pkg.sv
// config_pkg
// Shared definitions for the configuration path.
//   - Field widths of the ConfigStore shift register (clockConfig, adcScale,
//     dacScale) and the resulting frame length CONFIG_FRAME_BITS (18).
//   - spi_state_t: SPI front-end FSM states. Values come from localparam
//     constants so legacy code that compares raw 2-bit codes keeps working.
package config_pkg;

  localparam int CLOCK_CONFIG_W    = 6;
  localparam int ADC_SCALE_W       = 6;
  localparam int DAC_SCALE_W       = 6;
  localparam int CONFIG_FRAME_BITS = CLOCK_CONFIG_W + ADC_SCALE_W + DAC_SCALE_W;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;
  localparam logic [1:0] ST_OVERRUN   = 2'd3;

  typedef enum logic [1:0] {
    WAIT_IDLE = ST_WAIT_IDLE,
    IDLE      = ST_IDLE,
    ACTIVE    = ST_ACTIVE,
    OVERRUN   = ST_OVERRUN
  } spi_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Multi-flop synchronizer for one asynchronous input followed by registered
// rise/fall detection.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-low reset (chain clears to 0)
//   i_async  in  asynchronous input
//   o_level  out synchronized level, aligned with o_rise/o_fall
//   o_rise   out one-cycle pulse on a synchronized 0->1 transition
//   o_fall   out one-cycle pulse on a synchronized 1->0 transition
// Latency: an input sampled high on clk edge e gives o_rise high after edge
// e+SYNC_STAGES. o_level after the same edge is the value sampled at e.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/config_spi_bridge.sv
// config_spi_bridge
// SPI mode-0 slave (MSB first) front end for the ConfigStore shift register.
// Converts asynchronous SCLK/MOSI activity into single-cycle shift strobes,
// returns ConfigStore serialOut on MISO, and checks frame length.
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous, active-low reset
//   spiCsN      in  chip select, active low, asynchronous
//   spiSclk     in  SPI clock, asynchronous, at most clk/4
//   spiMosi     in  SPI data in, asynchronous
//   spiMiso     out SPI data out, registered
//   serialEn    out one-cycle shift strobe to ConfigStore
//   serialIn    out bit to shift in, valid while serialEn=1
//   serialOut   in  ConfigStore shift-out bit
//   frameDone   out one-cycle pulse: frame closed with exactly FRAME_BITS bits
//   frameError  out one-cycle pulse: frame closed with a wrong non-zero count
//   o_dbg_state out current FSM state (spi_state_t encoding)
// Build option: define CONFIG_SPI_READBACK_EN to drive spiMiso from
// serialOut. Without it spiMiso is 0 and serialOut is ignored.
// Strobe interface: serialEn is a pure push strobe with no back-pressure;
// ConfigStore shifts serialIn on every clk cycle in which serialEn is 1.
module config_spi_bridge
  import config_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = CONFIG_FRAME_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spiCsN,
  input  logic       spiSclk,
  input  logic       spiMosi,
  output logic       spiMiso,
  output logic       serialEn,
  output logic       serialIn,
  input  logic       serialOut,
  output logic       frameDone,
  output logic       frameError,
  output logic [1:0] o_dbg_state
);

  localparam int              CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FRAME_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  logic w_sclk_level;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_n_level;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;
  logic w_unused;

  logic [SYNC_STAGES:0] r_mosi_sync;
  spi_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic                 r_en;
  logic                 r_in;
  logic                 r_done;
  logic                 r_err;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (spiSclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (spiCsN),
    .o_level (w_cs_n_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // One extra flop beyond the synchronizer depth so MOSI lines up with the
  // registered SCLK edge pulse: the bit used is the one sampled together
  // with the SCLK rise, before the host changes it on the next fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], spiMosi};
    end
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b0;
      r_in    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        // Do not join a frame that was already running when reset lifted.
        WAIT_IDLE: if (w_cs_n_level) r_state <= IDLE;
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= ACTIVE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        ACTIVE, OVERRUN: begin
          // CS rise takes priority over a coincident SCLK rise.
          if (w_cs_rise) begin
            r_state <= IDLE;
            if (r_cnt == FRAME_FULL && !r_ovf) r_done <= 1'b1;
            else if (r_cnt != '0)              r_err  <= 1'b1;
          end else if (w_sclk_rise) begin
            if (r_state == ACTIVE) begin
              r_en  <= 1'b1;
              r_in  <= w_mosi;
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == FRAME_LAST) r_state <= OVERRUN;
            end else begin
              // Counter stays saturated; only remember the overflow.
              r_ovf <= 1'b1;
            end
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef CONFIG_SPI_READBACK_EN
  logic r_miso;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_miso <= 1'b0;
    end else if ((r_state == IDLE && w_cs_fall) ||
                 (r_state == ACTIVE && w_sclk_fall)) begin
      r_miso <= serialOut;
    end
  end

  assign spiMiso  = r_miso;
  assign w_unused = w_sclk_level;
`else
  assign spiMiso  = 1'b0;
  assign w_unused = ^{w_sclk_level, w_sclk_fall, serialOut};
`endif

  assign serialEn    = r_en;
  assign serialIn    = r_in;
  assign frameDone   = r_done;
  assign frameError  = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_config_spi_bridge.sv
`timescale 1ns/1ps
module tb_config_spi_bridge;
  import config_pkg::*;

  localparam int SYNC = 2;
  localparam int FB   = 18;
  localparam int LAT  = SYNC + 1;
  localparam int HALF = 4;
  localparam int EW   = 35;

  // ---------------- clock / reset / pins ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic cs_n  = 1'b1;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic miso, s_en, s_in, s_out, f_done, f_err;
  logic [1:0] dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ConfigStore model: MSB shifts out, new bit enters at the LSB.
  logic [17:0] store       = '0;
  logic [17:0] preload_val = '0;
  logic        preload_req = 1'b0;
  always @(posedge clk) begin
    if (preload_req) store <= preload_val;
    else if (s_en)   store <= {store[16:0], s_in};
  end
  assign s_out = store[17];

  config_spi_bridge #(.SYNC_STAGES(SYNC), .FRAME_BITS(FB)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .spiCsN      (cs_n),
    .spiSclk     (sclk),
    .spiMosi     (mosi),
    .spiMiso     (miso),
    .serialEn    (s_en),
    .serialIn    (s_in),
    .serialOut   (s_out),
    .frameDone   (f_done),
    .frameError  (f_err),
    .o_dbg_state (dbg)
  );

  // ---------------- scoreboard ----------------
  // entry = {kind[1:0], bit, cycle[31:0]}; kind 0 strobe, 1 done, 2 error
  logic [EW-1:0] exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_on  = 1'b0;

  // Frame-level model of the host-visible behaviour.
  bit  m_armed    = 1'b0;
  bit  m_in_frame = 1'b0;
  bit  m_ovf      = 1'b0;
  int  m_cnt      = 0;

  int          seen_en   = 0;
  int          seen_done = 0;
  int          seen_err  = 0;
  logic [17:0] seen_bits = '0;
  logic [17:0] cap       = '0;
  logic [17:0] exp_rb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_evt(input logic [1:0] kind, input logic b, input int at);
    exp_q.push_back({kind, b, 32'(at)});
  endtask

  logic [EW-1:0] cmp_ent;
  logic [3:0]    cmp_exp;
  logic [3:0]    cmp_act;

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_exp = '0;
      while (exp_q.size() > 0) begin
        cmp_ent = exp_q[0];
        if (int'(cmp_ent[31:0]) > cyc) break;
        void'(exp_q.pop_front());
        case (cmp_ent[34:33])
          2'd0:    cmp_exp[3:2] = {1'b1, cmp_ent[32]};
          2'd1:    cmp_exp[1]   = 1'b1;
          2'd2:    cmp_exp[0]   = 1'b1;
          default: ;
        endcase
      end
      cmp_act = {s_en, s_en & s_in, f_done, f_err};
      check("cycle_outputs{en,in,done,err}", {28'd0, cmp_act}, {28'd0, cmp_exp});
      if (s_en === 1'b1) begin
        seen_en++;
        seen_bits = {seen_bits[16:0], s_in};
      end
      if (f_done === 1'b1) seen_done++;
      if (f_err === 1'b1)  seen_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic clear_seen();
    seen_en   = 0;
    seen_done = 0;
    seen_err  = 0;
    seen_bits = '0;
    cap       = '0;
  endtask

  task automatic preload(input logic [17:0] v);
    preload_val = v;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
  endtask

  // Inputs driven now are first sampled on clk edge cyc+1.
  task automatic set_cs(input logic v);
    int e;
    e = cyc + 1;
    if (cs_n && !v) begin
      if (m_armed) begin
        m_in_frame = 1'b1;
        m_cnt      = 0;
        m_ovf      = 1'b0;
      end
    end else if (!cs_n && v) begin
      m_armed = 1'b1;
      if (m_in_frame) begin
        if (m_cnt == FB && !m_ovf) push_evt(2'd1, 1'b0, e + LAT);
        else if (m_cnt != 0)       push_evt(2'd2, 1'b0, e + LAT);
        m_in_frame = 1'b0;
      end
    end
    cs_n = v;
  endtask

  task automatic sclk_up();
    int e;
    e = cyc + 1;
    cap = {cap[16:0], miso};
    if (m_in_frame) begin
      if (m_cnt < FB) begin
        push_evt(2'd0, mosi, e + LAT);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    sclk = 1'b1;
  endtask

  task automatic shift_bit(input logic b);
    mosi = b;
    wait_cycles(HALF);
    sclk_up();
    wait_cycles(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input bit cs_on_last);
    set_cs(1'b0);
    wait_cycles(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (cs_on_last && i == nbits - 1) begin
        mosi = data[nbits-1-i];
        wait_cycles(HALF);
        set_cs(1'b1);
        sclk = 1'b1;
        wait_cycles(HALF);
        sclk = 1'b0;
      end else begin
        shift_bit(data[nbits-1-i]);
      end
    end
    if (!cs_on_last) begin
      wait_cycles(HALF);
      set_cs(1'b1);
    end
    wait_cycles(12);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    rst_n  = 1'b0;
    chk_on = 1'b1;
    #1;
    check("reset_outputs", {27'd0, miso, s_en, s_in, f_done, f_err}, 32'd0);
    check("reset_state", {30'd0, dbg}, {30'd0, WAIT_IDLE});
    wait_cycles(5);
    rst_n   = 1'b1;
    m_armed = cs_n;
    wait_cycles(10);
    check("idle_after_reset", {30'd0, dbg}, {30'd0, IDLE});

    // Full frame
    clear_seen();
    send_frame(32'h2A5C3, 18, 1'b0);
    check("full_strobes", 32'(seen_en), 32'd18);
    check("full_bits", {14'd0, seen_bits}, 32'h2A5C3);
    check("full_done", 32'(seen_done), 32'd1);
    check("full_err", 32'(seen_err), 32'd0);
    check("full_store", {14'd0, store}, 32'h2A5C3);

    // Readback of preloaded ConfigStore
    preload(18'h3F00A);
    clear_seen();
    send_frame(32'h0, 18, 1'b0);
`ifdef CONFIG_SPI_READBACK_EN
    exp_rb = 18'h3F00A;
`else
    exp_rb = 18'h0;
`endif
    check("readback_miso", {14'd0, cap}, {14'd0, exp_rb});
    check("readback_done", 32'(seen_done), 32'd1);

    // Short frame
    clear_seen();
    send_frame(32'h2B5, 10, 1'b0);
    check("short_strobes", 32'(seen_en), 32'd10);
    check("short_err", 32'(seen_err), 32'd1);
    check("short_done", 32'(seen_done), 32'd0);

    // Overlong frame: only the first 18 bits reach ConfigStore
    clear_seen();
    send_frame(32'hABCDE, 20, 1'b0);
    check("long_strobes", 32'(seen_en), 32'd18);
    check("long_bits", {14'd0, seen_bits}, 32'h2AF37);
    check("long_err", 32'(seen_err), 32'd1);
    check("long_done", 32'(seen_done), 32'd0);

    // CS pulse without SCLK
    clear_seen();
    set_cs(1'b0);
    wait_cycles(8);
    set_cs(1'b1);
    wait_cycles(12);
    check("empty_pulses", 32'(seen_en + seen_done + seen_err), 32'd0);

    // Reset after 7 bits with CS held low
    clear_seen();
    set_cs(1'b0);
    wait_cycles(HALF);
    for (int i = 0; i < 7; i++) shift_bit(i[0]);
    wait_cycles(6);
    check("pre_reset_strobes", 32'(seen_en), 32'd7);
    rst_n = 1'b0;
    exp_q.delete();
    m_armed    = 1'b0;
    m_in_frame = 1'b0;
    #1;
    check("midframe_reset_outputs", {27'd0, miso, s_en, s_in, f_done, f_err}, 32'd0);
    clear_seen();
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    wait_cycles(10);
    check("post_reset_ignored", 32'(seen_en + seen_done + seen_err), 32'd0);
    set_cs(1'b1);
    wait_cycles(10);
    send_frame(32'h0F0F5, 18, 1'b0);
    check("post_reset_strobes", 32'(seen_en), 32'd18);
    check("post_reset_done", 32'(seen_done), 32'd1);

    // CS rise coincident with the 18th SCLK rise
    clear_seen();
    send_frame(32'h15555, 18, 1'b1);
    check("coinc_strobes", 32'(seen_en), 32'd17);
    check("coinc_err", 32'(seen_err), 32'd1);
    check("coinc_done", 32'(seen_done), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $fatal(1, "watchdog expired");
  end

endmodule
